// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-ported data memory.
// Converts stores to byte-lane codes, drains one per idle memory cycle and stalls same-word loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        St_Req,
    input  logic [1:0]  St_Type,
    input  logic [31:0] St_Addr,
    input  logic [31:0] St_Data,
    output logic        St_Stall,
    output logic        AdES,
    input  logic        Ld_Req,
    input  logic [31:0] Ld_Addr,
    output logic        Ld_Stall,
    output logic [31:0] DM_Addr,
    output logic [3:0]  DM_Bit_Type,
    output logic [31:0] DM_WriteData,
    output logic        DM_WriteEnabled,
    output logic        Empty,
    output logic [AW:0] Count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [1:0]  ST_SW      = 2'b00;
    localparam logic [1:0]  ST_SH      = 2'b01;
    localparam logic [1:0]  ST_SB      = 2'b10;

    logic [31:0]   addr_q [DEPTH];
    logic [3:0]    bt_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          valid_type;
    logic          misaligned;
    logic          st_ok;
    logic          ld_match;
    logic          ld_hazard;
    logic          drain;
    logic          enq;
    logic [3:0]    st_bit_type;
    logic [AW-1:0] rel;
    logic          ld_addr_unused;

    assign ld_addr_unused = ^{Ld_Addr[31:13], Ld_Addr[1:0]};

    assign valid_type = (St_Type != 2'b11);
    assign misaligned = ((St_Type == ST_SW) && (St_Addr[1:0] != 2'b00)) ||
                        ((St_Type == ST_SH) && St_Addr[0]);
    assign st_ok      = St_Req && valid_type && !misaligned;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        st_bit_type = 4'b0000;
        case (St_Type)
            ST_SW:   st_bit_type = 4'b1111;
            ST_SH:   st_bit_type = St_Addr[1] ? 4'b1100 : 4'b0011;
            ST_SB:   st_bit_type = 4'b0001 << St_Addr[1:0];
            default: st_bit_type = 4'b0000;
        endcase
    end

    // An entry is live when its distance from head (mod DEPTH) is below the count.
    always_comb begin
        ld_match = 1'b0;
        rel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = AW'(i) - head_q;
            if (({1'b0, rel} < count_q) && (addr_q[i][12:2] == Ld_Addr[12:2])) begin
                ld_match = 1'b1;
            end
        end
    end

    assign ld_hazard = Ld_Req && ld_match;
    assign drain     = !reset && (count_q != '0) && (!Ld_Req || ld_hazard);
    assign enq       = !reset && st_ok && ((count_q != FULL_COUNT) || drain);

    assign St_Stall        = !reset && st_ok && (count_q == FULL_COUNT) && !drain;
    assign AdES            = !reset && St_Req && misaligned;
    assign Ld_Stall        = !reset && ld_hazard;
    assign DM_WriteEnabled = drain;
    assign DM_Addr         = addr_q[head_q];
    assign DM_Bit_Type     = bt_q[head_q];
    assign DM_WriteData    = data_q[head_q];
    assign Empty           = (count_q == '0);
    assign Count           = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + AW'(1);
        end
        if (enq) begin
            tail_d = tail_q + AW'(1);
        end
        if (enq && !drain) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!enq && drain) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is not reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= St_Addr;
            bt_q[tail_q]   <= st_bit_type;
            data_q[tail_q] <= St_Data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model, drain scoreboard and word memory.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        St_Req;
    logic [1:0]  St_Type;
    logic [31:0] St_Addr;
    logic [31:0] St_Data;
    logic        St_Stall;
    logic        AdES;
    logic        Ld_Req;
    logic [31:0] Ld_Addr;
    logic        Ld_Stall;
    logic [31:0] DM_Addr;
    logic [3:0]  DM_Bit_Type;
    logic [31:0] DM_WriteData;
    logic        DM_WriteEnabled;
    logic        Empty;
    logic [2:0]  Count;

    store_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .St_Req(St_Req), .St_Type(St_Type), .St_Addr(St_Addr), .St_Data(St_Data),
        .St_Stall(St_Stall), .AdES(AdES),
        .Ld_Req(Ld_Req), .Ld_Addr(Ld_Addr), .Ld_Stall(Ld_Stall),
        .DM_Addr(DM_Addr), .DM_Bit_Type(DM_Bit_Type), .DM_WriteData(DM_WriteData),
        .DM_WriteEnabled(DM_WriteEnabled), .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bt;
        logic [31:0] data;
    } ent_t;

    ent_t        model_q[$];
    ent_t        sb_q[$];
    logic [31:0] mem [bit [31:0]];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory side: every strobe must match the oldest outstanding store, then updates the word memory.
    always @(negedge clk) begin
        if (DM_WriteEnabled === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_drain", 32'd1, 32'd0);
            end else begin
                ent_t        e;
                logic [31:0] w;
                e = sb_q.pop_front();
                check("dm_addr", DM_Addr, e.addr);
                check("dm_bit_type", 32'(DM_Bit_Type), 32'(e.bt));
                check("dm_wdata", DM_WriteData, e.data);
                w = mem.exists(DM_Addr >> 2) ? mem[DM_Addr >> 2] : 32'h0;
                for (int k = 0; k < 4; k++) begin
                    if (DM_Bit_Type[k]) begin
                        if (DM_Bit_Type == 4'b1111)      w[8*k +: 8] = DM_WriteData[8*k +: 8];
                        else if (DM_Bit_Type == 4'b0011 ||
                                 DM_Bit_Type == 4'b1100) w[8*k +: 8] = DM_WriteData[8*(k%2) +: 8];
                        else                             w[8*k +: 8] = DM_WriteData[7:0];
                    end
                end
                mem[DM_Addr >> 2] = w;
            end
        end
    end

    // Drive one cycle of inputs, compare status outputs with the model, then advance the model.
    task automatic cycle(input logic sr, input logic [1:0] st, input logic [31:0] sa,
                         input logic [31:0] sd, input logic lr, input logic [31:0] la,
                         input logic rs);
        logic e_ld, e_drain, e_mis, e_ok, e_enq, e_stst, e_ades;
        int   n;
        reset = rs; St_Req = sr; St_Type = st; St_Addr = sa; St_Data = sd;
        Ld_Req = lr; Ld_Addr = la;
        #2;
        n    = model_q.size();
        e_ld = 1'b0;
        foreach (model_q[i]) if (lr && model_q[i].addr[12:2] == la[12:2]) e_ld = 1'b1;
        e_mis   = (st == 2'b00 && sa[1:0] != 2'b00) || (st == 2'b01 && sa[0]);
        e_ok    = sr && st != 2'b11 && !e_mis;
        e_drain = n > 0 && (!lr || e_ld);
        e_enq   = e_ok && (n < 4 || e_drain);
        e_stst  = e_ok && n == 4 && !e_drain;
        e_ades  = sr && e_mis;
        if (rs) begin
            e_ld = 1'b0; e_drain = 1'b0; e_enq = 1'b0; e_stst = 1'b0; e_ades = 1'b0;
        end
        check("count", 32'(Count), 32'(n));
        check("empty", 32'(Empty), 32'(n == 0));
        check("dm_we", 32'(DM_WriteEnabled), 32'(e_drain));
        check("ld_stall", 32'(Ld_Stall), 32'(e_ld));
        check("st_stall", 32'(St_Stall), 32'(e_stst));
        check("ades", 32'(AdES), 32'(e_ades));
        if (rs) begin
            model_q.delete();
            sb_q.delete();
        end else begin
            if (e_drain) void'(model_q.pop_front());
            if (e_enq) begin
                ent_t e;
                e.addr = sa;
                e.data = sd;
                e.bt   = (st == 2'b00) ? 4'b1111 :
                         (st == 2'b01) ? (4'b0011 << sa[1:0]) : (4'b0001 << sa[1:0]);
                model_q.push_back(e);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; St_Req = 1'b0; St_Type = 2'b00; St_Addr = '0; St_Data = '0;
        Ld_Req = 1'b0; Ld_Addr = '0;
        @(posedge clk);
        #1;
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Single sw drains the next cycle.
        cycle(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        idle(2);

        // Fill under a held non-matching load, overflow stall, then shared enqueue/drain.
        cycle(1'b1, 2'b01, 32'h22, 32'h1234, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 2'b10, 32'h13, 32'hAB, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 2'b10, 32'h11, 32'hAB, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 2'b10, 32'h10, 32'hAB, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 2'b00, 32'h30, 32'h55AA55AA, 1'b1, 32'h100, 1'b0);
        cycle(1'b1, 2'b00, 32'h30, 32'h55AA55AA, 1'b0, 32'h0, 1'b0);
        idle(5);

        // Load hazard resolves by draining the matching store.
        cycle(1'b1, 2'b00, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
        check("mem_0x40", mem.exists(32'h10) ? mem[32'h10] : 32'h0, 32'hCAFEF00D);

        // Misaligned and reserved stores.
        cycle(1'b1, 2'b00, 32'h41, 32'h1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b01, 32'h43, 32'h2, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 2'b11, 32'h44, 32'h3, 1'b0, 32'h0, 1'b0);
        idle(1);

        // Reset with pending stores discards them.
        cycle(1'b1, 2'b00, 32'h60, 32'h11111111, 1'b1, 32'h200, 1'b0);
        cycle(1'b1, 2'b00, 32'h64, 32'h22222222, 1'b1, 32'h200, 1'b0);
        cycle(1'b1, 2'b00, 32'h68, 32'h33333333, 1'b1, 32'h200, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom & 32'h3F, $urandom,
                  ($urandom_range(0, 2) == 0), $urandom & 32'h203F, ($urandom_range(0, 63) == 0));
        end
        idle(6);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO that sits directly upstream of the data memory in the MEM stage.
- Accepts stores from the pipeline, validates alignment, and converts each store to the data memory's byte-lane code (Bit_Type).
- Drains one entry per cycle into the data memory write port. The data memory is treated as single-ported, so a drain never shares a cycle with a load.
- Stalls any load whose word address matches a pending store until that store has been drained.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high reset.
- St_Req, in, 1, store request this cycle.
- St_Type, in, 2, store size: 00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- St_Addr, in, 32, store byte address.
- St_Data, in, 32, store data, unshifted: sh uses bits [15:0], sb uses bits [7:0].
- St_Stall, out, 1, store not accepted this cycle; the pipeline holds the store.
- AdES, out, 1, misaligned-store exception for this cycle's request.
- Ld_Req, in, 1, load request this cycle.
- Ld_Addr, in, 32, load byte address.
- Ld_Stall, out, 1, load must wait for a pending store to the same word.
- DM_Addr, out, 32, address to the data memory; head entry.
- DM_Bit_Type, out, 4, byte-lane code to the data memory; head entry.
- DM_WriteData, out, 32, write data to the data memory; head entry.
- DM_WriteEnabled, out, 1, data memory write strobe.
- Empty, out, 1, no valid entries.
- Count, out, AW+1, number of valid entries.

Behaviour:
- State:
  - Circular array of DEPTH entries, each {Addr[31:0], Bit_Type[3:0], Data[31:0]}.
  - Head and tail pointers, AW bits each, wrapping modulo DEPTH.
  - Count register, AW+1 bits.
- Reset (sync, active-high): head = tail = Count = 0.
  - While reset is high, force DM_WriteEnabled = 0, St_Stall = 0, Ld_Stall = 0, AdES = 0.
  - Entry contents are don't-care after reset.
  - Reset mid-operation discards all pending stores; no partial drain.
- Alignment check (combinational): misaligned = (sw && St_Addr[1:0] != 0) || (sh && St_Addr[0] != 0).
  - AdES = St_Req && misaligned && !reset.
  - Misaligned stores and St_Type = 11 are never enqueued and never stall.
- Bit_Type encoding at enqueue, from st_off = St_Addr[1:0]:
  - sw: 1111.
  - sh: 0011 if st_off = 0, 1100 if st_off = 2.
  - sb: 0001 << st_off.
  - Data is stored unshifted.
- Drain:
  - drain = !Empty && (!Ld_Req || Ld_Stall).
  - DM_WriteEnabled = drain.
  - DM_Addr, DM_Bit_Type and DM_WriteData are driven combinationally from the head entry.
  - On the clock edge when drain is high, head advances. A write becomes visible in memory on the same edge.
- Enqueue:
  - enq = St_Req && valid type && !misaligned && (Count < DEPTH || drain).
  - St_Stall = St_Req && valid type && !misaligned && Count == DEPTH && !drain.
  - On the edge when enq is high: the entry is written at tail and tail advances.
- Count update: Count += enq − drain. Simultaneous enq and drain leaves Count unchanged, including when Count = DEPTH.
- Load hazard:
  - Ld_Stall = Ld_Req && (Ld_Addr[12:2] equals Addr[12:2] of any valid entry).
  - The check is conservative and ignores byte lanes.
  - Loads that do not match proceed and block the drain in that cycle.
  - Ld_Stall drops the cycle after the last matching entry drains.
- St_Req and Ld_Req in the same cycle:
  - The store is evaluated normally.
  - The load check covers only entries valid before the edge; the same-cycle store is excluded.
- Ordering: strict FIFO. Multiple stores to the same word drain in program order.
- Empty = (Count == 0). All status outputs are combinational from registers.

Test Plan:
1. Reset, then sw St_Addr = 0x10, St_Data = 0xDEADBEEF with Ld_Req = 0 → next cycle Count = 1 and DM_WriteEnabled = 1 with DM_Bit_Type = 1111, DM_Addr = 0x10, DM_WriteData = 0xDEADBEEF; the following cycle Empty = 1.
2. With Ld_Req held high to a non-matching address, issue sh to 0x22 (data 0x1234), then sb to 0x13, 0x11, 0x10 (data 0xAB) → no drains while the load is held. Buffer holds Bit_Type 1100, 1000, 0010, 0001 in order and Count = 4. A fifth store asserts St_Stall. When Ld_Req drops, the entries drain in order, one per cycle.
3. Full buffer with Ld_Req low and St_Req high in the same cycle → St_Stall = 0, enqueue and drain occur together, and Count stays 4; tail wraps past entry 3 to entry 0.
4. Pending sw to 0x40, then load 0x42 → Ld_Stall = 1 and DM_WriteEnabled = 1 in the same cycle; next cycle Ld_Stall = 0 and memory word 0x40 already holds the new data.
5. sw to 0x41 and sh to 0x43 → AdES = 1 for each, Count unchanged, no stall. St_Type = 11 → AdES = 0 and nothing is enqueued.
6. Three entries pending, then reset asserted for one cycle → Count = 0, Empty = 1, DM_WriteEnabled = 0 during and after reset; memory receives no further writes.
